regfile_sequencer: RTL and testbench

Command sequencer for the 8 x 16-bit register file. Accepts IN, MOVE, OUT and SWAP commands over a valid/ready handshake. Expands each command into the register file's single-port read/write cycle sequence and presents OUT results with a one-cycle valid strobe. Sits between the top-level command source and the register file, replacing ad-hoc op-code sequencing by the command source.

---
 rtl/regfile_sequencer.sv | 157 +++++++++++++++
 tb/tb_regfile_sequencer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sequencer.sv
// Command sequencer for an 8 x 16-bit single-port register file: expands IN/MOVE/OUT/SWAP
// into read/capture/write cycles. Every output except cmd_ready comes straight from a flop.
module regfile_sequencer #(
  parameter int DW = 16,
  parameter int AW = 3
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [AW-1:0] cmd_src,
  input  logic [AW-1:0] cmd_dst,
  input  logic [DW-1:0] cmd_data,
  output logic [AW-1:0] rf_code,
  output logic [DW-1:0] rf_wdata,
  output logic          rf_we,
  output logic          rf_re,
  input  logic [DW-1:0] rf_rdata,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          done,
  output logic [7:0]    cmd_count
);

  typedef enum logic [2:0] {S_IDLE, S_RD_A, S_RD_B, S_CAP, S_WR_A, S_WR_B} state_t;
  typedef enum logic [1:0] {OP_IN, OP_MOVE, OP_OUT, OP_SWAP} op_t;

  state_t        state_q, state_d;
  op_t           op_q, op_d;
  logic [AW-1:0] src_q, src_d, dst_q, dst_d, rf_code_q, rf_code_d;
  logic [DW-1:0] data_q, data_d, tmp_a_q, tmp_a_d, tmp_b_q, tmp_b_d;
  logic [DW-1:0] rf_wdata_q, rf_wdata_d, out_data_q, out_data_d;
  logic          rf_we_q, rf_we_d, rf_re_q, rf_re_d;
  logic          out_valid_q, out_valid_d, done_q, done_d;
  logic [7:0]    cmd_count_q, cmd_count_d;

  assign cmd_ready = (state_q == S_IDLE) && !reset;

  always_comb begin
    // NOTE: every _d starts from its held value (or 0 for strobes) so no path infers a latch.
    state_d     = state_q;
    op_d        = op_q;
    src_d       = src_q;
    dst_d       = dst_q;
    data_d      = data_q;
    tmp_a_d     = tmp_a_q;
    tmp_b_d     = tmp_b_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d    = op_t'(cmd_op);
          src_d   = cmd_src;
          dst_d   = cmd_dst;
          data_d  = cmd_data;
          state_d = (op_t'(cmd_op) == OP_IN) ? S_WR_A : S_RD_A;
        end
      end
      S_RD_A: state_d = (op_q == OP_SWAP) ? S_RD_B : S_CAP;
      S_RD_B: begin
        tmp_a_d = rf_rdata;
        state_d = S_CAP;
      end
      S_CAP: begin
        case (op_q)
          OP_OUT: begin
            out_data_d  = rf_rdata;
            out_valid_d = 1'b1;
            state_d     = S_IDLE;
          end
          OP_SWAP: begin
            tmp_b_d = rf_rdata;
            state_d = S_WR_A;
          end
          default: begin
            tmp_a_d = rf_rdata;
            state_d = S_WR_A;
          end
        endcase
      end
      S_WR_A:  state_d = (op_q == OP_SWAP) ? S_WR_B : S_IDLE;
      S_WR_B:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Register-file strobes are decoded from the next state so they line up with it.
    done_d      = (state_q != S_IDLE) && (state_d == S_IDLE);
    cmd_count_d = cmd_count_q + {7'd0, done_d};
    rf_we_d     = (state_d == S_WR_A) || (state_d == S_WR_B);
    rf_re_d     = (state_d == S_RD_A) || (state_d == S_RD_B);
    rf_code_d   = '0;
    rf_wdata_d  = '0;
    case (state_d)
      S_RD_A: rf_code_d = src_d;
      S_RD_B: rf_code_d = dst_d;
      S_WR_A: begin
        rf_code_d  = dst_d;
        rf_wdata_d = (op_d == OP_IN) ? data_d : tmp_a_d;
      end
      S_WR_B: begin
        rf_code_d  = src_d;
        rf_wdata_d = tmp_b_d;
      end
      default: ;
    endcase
  end

  // NOTE: state flops use non-blocking assignments so all of them update from pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      op_q        <= OP_IN;
      src_q       <= '0;
      dst_q       <= '0;
      data_q      <= '0;
      tmp_a_q     <= '0;
      tmp_b_q     <= '0;
      rf_code_q   <= '0;
      rf_wdata_q  <= '0;
      rf_we_q     <= 1'b0;
      rf_re_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      done_q      <= 1'b0;
      cmd_count_q <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      data_q      <= data_d;
      tmp_a_q     <= tmp_a_d;
      tmp_b_q     <= tmp_b_d;
      rf_code_q   <= rf_code_d;
      rf_wdata_q  <= rf_wdata_d;
      rf_we_q     <= rf_we_d;
      rf_re_q     <= rf_re_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      done_q      <= done_d;
      cmd_count_q <= cmd_count_d;
    end
  end

  assign rf_code   = rf_code_q;
  assign rf_wdata  = rf_wdata_q;
  assign rf_we     = rf_we_q;
  assign rf_re     = rf_re_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign done      = done_q;
  assign cmd_count = cmd_count_q;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Directed bench for regfile_sequencer with a behavioural register file, a shadow
// register model and an OUT-result scoreboard queue.
module tb_regfile_sequencer;
  localparam int DW = 16;
  localparam int AW = 3;
  localparam logic [1:0] OP_IN = 2'd0, OP_MOVE = 2'd1, OP_OUT = 2'd2, OP_SWAP = 2'd3;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = '0;
  logic [AW-1:0] cmd_src = '0;
  logic [AW-1:0] cmd_dst = '0;
  logic [DW-1:0] cmd_data = '0;
  logic [AW-1:0] rf_code;
  logic [DW-1:0] rf_wdata;
  logic          rf_we, rf_re;
  logic [DW-1:0] rf_rdata = '0;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          done;
  logic [7:0]    cmd_count;

  int n_assert = 0;
  int n_fail   = 0;
  int n_out_seen = 0;

  logic [DW-1:0] rf_mem [8];
  logic [DW-1:0] exp_rf [8];
  logic [DW-1:0] out_q [$];
  bit            watch_no_we = 1'b0;

  logic          tr_we [8], tr_re [8], tr_ov [8];
  logic [AW-1:0] tr_code [8];
  logic [DW-1:0] tr_wdata [8];

  regfile_sequencer #(.DW(DW), .AW(AW)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_data(cmd_data),
    .rf_code(rf_code), .rf_wdata(rf_wdata), .rf_we(rf_we), .rf_re(rf_re),
    .rf_rdata(rf_rdata), .out_valid(out_valid), .out_data(out_data),
    .done(done), .cmd_count(cmd_count)
  );

  always #5 clock = ~clock;

  // Behavioural single-port register file: write on the edge, read data the cycle after rf_re.
  always @(posedge clock) begin
    if (rf_we) rf_mem[rf_code] <= rf_wdata;
    if (rf_re) rf_rdata <= rf_mem[rf_code];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Continuous monitors: strobe exclusivity, OUT scoreboard, no writes during an abort.
  always @(negedge clock) begin
    if (!reset) begin
      check("we_re_exclusive", 32'(rf_we & rf_re), 0);
      if (out_valid === 1'b1) begin
        n_out_seen++;
        if (out_q.size() == 0) check("unexpected_out_valid", 32'(out_valid), 0);
        else check("out_data_scoreboard", 32'(out_data), 32'(out_q.pop_front()));
      end
    end
    if (watch_no_we) check("no_we_during_abort", 32'(rf_we), 0);
  end

  // Issues one command, traces cycles 1..k+1, checks done/cmd_ready timing, updates the shadow model.
  task automatic run_cmd(input logic [1:0] op, input logic [AW-1:0] src, input logic [AW-1:0] dst,
                         input logic [DW-1:0] data, input bit scramble);
    int k;
    int budget;
    logic [DW-1:0] tmp;
    k = (op == OP_IN) ? 1 : (op == OP_OUT) ? 2 : (op == OP_MOVE) ? 3 : 5;
    budget = 0;
    while (cmd_ready !== 1'b1 && budget < 16) begin
      @(negedge clock);
      budget++;
    end
    check("ready_at_issue", 32'(cmd_ready), 1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_src   = src;
    cmd_dst   = dst;
    cmd_data  = data;
    case (op)
      OP_IN:   exp_rf[dst] = data;
      OP_MOVE: exp_rf[dst] = exp_rf[src];
      OP_OUT:  out_q.push_back(exp_rf[src]);
      default: begin
        tmp         = exp_rf[src];
        exp_rf[src] = exp_rf[dst];
        exp_rf[dst] = tmp;
      end
    endcase
    @(posedge clock);
    for (int n = 1; n <= k + 1; n++) begin
      @(negedge clock);
      tr_we[n]    = rf_we;
      tr_re[n]    = rf_re;
      tr_ov[n]    = out_valid;
      tr_code[n]  = rf_code;
      tr_wdata[n] = rf_wdata;
      check("done_timing", 32'(done), (n == k + 1) ? 1 : 0);
      check("ready_timing", 32'(cmd_ready), (n == k + 1) ? 1 : 0);
      if (n == 1) begin
        cmd_op    = 2'($urandom_range(0, 3));
        cmd_src   = 3'($urandom_range(0, 7));
        cmd_dst   = 3'($urandom_range(0, 7));
        cmd_data  = 16'($urandom);
        cmd_valid = scramble;
      end
    end
    cmd_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clock);
    check("rst_ready", 32'(cmd_ready), 0);
    check("rst_we", 32'(rf_we), 0);
    check("rst_re", 32'(rf_re), 0);
    check("rst_code", 32'(rf_code), 0);
    check("rst_wdata", 32'(rf_wdata), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_done", 32'(done), 0);
    check("rst_count", 32'(cmd_count), 0);
    reset = 1'b0;
    @(negedge clock);
    check("ready_after_release", 32'(cmd_ready), 1);

    // Back-to-back IN R0=77, IN R7=45
    run_cmd(OP_IN, 3'd0, 3'd0, 16'd77, 1'b0);
    check("in0_we_c1", 32'(tr_we[1]), 1);
    check("in0_re_c1", 32'(tr_re[1]), 0);
    check("in0_code_c1", 32'(tr_code[1]), 0);
    check("in0_wdata_c1", 32'(tr_wdata[1]), 77);
    run_cmd(OP_IN, 3'd0, 3'd7, 16'd45, 1'b0);
    check("in7_we_c1", 32'(tr_we[1]), 1);
    check("in7_code_c1", 32'(tr_code[1]), 7);
    check("in7_wdata_c1", 32'(tr_wdata[1]), 45);
    @(negedge clock);
    check("r0_after_in", 32'(rf_mem[0]), 77);
    check("r7_after_in", 32'(rf_mem[7]), 45);
    check("count_after_in", 32'(cmd_count), 2);

    // MOVE R7 -> R2
    run_cmd(OP_MOVE, 3'd7, 3'd2, 16'd0, 1'b0);
    check("move_re_c1", 32'(tr_re[1]), 1);
    check("move_code_c1", 32'(tr_code[1]), 7);
    check("move_we_c1", 32'(tr_we[1]), 0);
    check("move_we_c2", 32'(tr_we[2]), 0);
    check("move_we_c3", 32'(tr_we[3]), 1);
    check("move_code_c3", 32'(tr_code[3]), 2);
    check("move_wdata_c3", 32'(tr_wdata[3]), 45);
    @(negedge clock);
    check("r2_after_move", 32'(rf_mem[2]), 45);
    check("r7_after_move", 32'(rf_mem[7]), 45);

    // OUT R2
    run_cmd(OP_OUT, 3'd2, 3'd0, 16'd0, 1'b0);
    check("out_code_c1", 32'(tr_code[1]), 2);
    check("out_re_c1", 32'(tr_re[1]), 1);
    for (int n = 1; n <= 3; n++) begin
      check("out_valid_cycle", 32'(tr_ov[n]), (n == 3) ? 1 : 0);
      check("out_no_we", 32'(tr_we[n]), 0);
    end
    @(negedge clock);
    check("out_valid_one_cycle", 32'(out_valid), 0);
    check("out_data_held", 32'(out_data), 45);

    // SWAP R0 <-> R7
    run_cmd(OP_SWAP, 3'd0, 3'd7, 16'd0, 1'b0);
    check("swap_code_c2", 32'(tr_code[2]), 7);
    check("swap_we_c4", 32'(tr_we[4]), 1);
    check("swap_code_c4", 32'(tr_code[4]), 7);
    check("swap_wdata_c4", 32'(tr_wdata[4]), 77);
    check("swap_code_c5", 32'(tr_code[5]), 0);
    check("swap_wdata_c5", 32'(tr_wdata[5]), 45);
    @(negedge clock);
    check("r0_after_swap", 32'(rf_mem[0]), 45);
    check("r7_after_swap", 32'(rf_mem[7]), 77);

    // SWAP with src == dst
    run_cmd(OP_IN, 3'd0, 3'd4, 16'd30, 1'b0);
    run_cmd(OP_SWAP, 3'd4, 3'd4, 16'd0, 1'b0);
    check("self_swap_wdata_c4", 32'(tr_wdata[4]), 30);
    check("self_swap_wdata_c5", 32'(tr_wdata[5]), 30);
    @(negedge clock);
    check("r4_after_self_swap", 32'(rf_mem[4]), 30);

    // MOVE R0 -> R3 while cmd_* keep changing with cmd_valid held high
    run_cmd(OP_MOVE, 3'd0, 3'd3, 16'd0, 1'b1);
    check("latched_code_c1", 32'(tr_code[1]), 0);
    check("latched_code_c3", 32'(tr_code[3]), 3);
    check("latched_wdata_c3", 32'(tr_wdata[3]), 45);
    @(negedge clock);
    check("r3_after_move", 32'(rf_mem[3]), 45);
    run_cmd(OP_OUT, 3'd3, 3'd0, 16'd0, 1'b0);
    @(negedge clock);
    check("out_data_r3", 32'(out_data), 45);
    for (int i = 0; i < 8; i++)
      if (i == 0 || i == 2 || i == 3 || i == 4 || i == 7)
        check("shadow_model", 32'(rf_mem[i]), 32'(exp_rf[i]));

    // Reset in the CAP cycle of a SWAP, before WR_A
    check("ready_before_abort", 32'(cmd_ready), 1);
    cmd_valid = 1'b1;
    cmd_op    = OP_SWAP;
    cmd_src   = 3'd0;
    cmd_dst   = 3'd7;
    @(posedge clock);
    @(negedge clock);
    cmd_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    watch_no_we = 1'b1;
    reset = 1'b1;
    #1;
    check("abort_ready_low", 32'(cmd_ready), 0);
    check("abort_count", 32'(cmd_count), 0);
    repeat (3) begin
      @(negedge clock);
      check("abort_done_in_reset", 32'(done), 0);
    end
    reset = 1'b0;
    @(negedge clock);
    check("abort_ready_back", 32'(cmd_ready), 1);
    repeat (4) begin
      check("abort_done", 32'(done), 0);
      check("abort_count_zero", 32'(cmd_count), 0);
      @(negedge clock);
    end
    watch_no_we = 1'b0;
    check("abort_r0", 32'(rf_mem[0]), 45);
    check("abort_r7", 32'(rf_mem[7]), 77);

    // 257 IN commands: counter wraps 255 -> 0 and lands on 1
    for (int i = 0; i < 257; i++) run_cmd(OP_IN, 3'd0, 3'd1, 16'(i), 1'b0);
    @(negedge clock);
    check("count_wrap", 32'(cmd_count), 1);
    check("r1_last_in", 32'(rf_mem[1]), 256);

    check("scoreboard_drained", 32'(out_q.size()), 0);
    check("out_strobe_total", 32'(n_out_seen), 2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
